recursive_gaussian_iir_stage: RTL and testbench

- Sequential second-order recursive Gaussian IIR section for the recursive_gaussian datapath.
- Computes y[n] = n0*x[n] + n1*x[n-1] + d1*y[n-1] + d2*y[n-2] per sample, in 16-bit sign-magnitude fixed point with Q fractional bits.
- Sits directly downstream of the sign-magnitude adder stage and consumes its sums as x[n]. Feeds the next filter pass through a valid/ready stream.
- One time-shared multiplier and one accumulator per section. Four MAC cycles per sample.

---
 rtl/recursive_gaussian_iir_stage.sv | 165 ++++++++++++++++
 tb/tb_recursive_gaussian_iir_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/recursive_gaussian_iir_stage.sv
// Second-order recursive Gaussian IIR section, sign-magnitude fixed point.
// One shared multiplier and accumulator evaluate n0*x + n1*x1 + d1*y1 + d2*y2 over four cycles.
module recursive_gaussian_iir_stage #(
    parameter int Q = 12,
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         line_start,
    input  logic [N-1:0] coef_n0,
    input  logic [N-1:0] coef_n1,
    input  logic [N-1:0] coef_d1,
    input  logic [N-1:0] coef_d2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);
    localparam int M = N - 1;
    localparam logic [M-1:0] MAG_MAX = '1;

    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, DONE} state_t;

    state_t state_reg, state_next;

    logic [N-1:0] x_reg, x1_reg, y1_reg, y2_reg, acc_reg;
    logic [N-1:0] coef_in  [4];
    logic [N-1:0] coef_reg [4];
    logic         accept;

    logic [N-1:0]   mul_a, mul_b;
    logic [2*M-1:0] prod_full, prod_shift;
    logic [M-1:0]   prod_mag;
    logic           prod_sign;
    logic [M:0]     mag_sum;
    logic [M-1:0]   sum_mag;
    logic           sum_sign;

    // Negative zero is folded to +0 so downstream sign logic never sees it.
    function automatic logic [N-1:0] sm_norm(input logic [N-1:0] v);
        return (v[M-1:0] == '0) ? '0 : v;
    endfunction

    assign accept = in_ready && in_valid;

    assign coef_in[0] = coef_n0;
    assign coef_in[1] = coef_n1;
    assign coef_in[2] = coef_d1;
    assign coef_in[3] = coef_d2;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_coef
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    coef_reg[gi] <= '0;
                end else if (accept) begin
                    coef_reg[gi] <= sm_norm(coef_in[gi]);
                end
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (accept) state_next = T0;
            T0:      state_next = T1;
            T1:      state_next = T2;
            T2:      state_next = T3;
            T3:      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs; acc is frozen while in DONE, so out_data is stable until the handshake.
    always_comb begin
        in_ready  = (state_reg == IDLE) && rst_n;
        out_valid = (state_reg == DONE);
        out_data  = (state_reg == DONE) ? acc_reg : '0;
    end

    // Fixed MAC order: n0*x, n1*x1, d1*y1, d2*y2.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state_reg)
            T0: begin mul_a = coef_reg[0]; mul_b = x_reg;  end
            T1: begin mul_a = coef_reg[1]; mul_b = x1_reg; end
            T2: begin mul_a = coef_reg[2]; mul_b = y1_reg; end
            T3: begin mul_a = coef_reg[3]; mul_b = y2_reg; end
            default: ;
        endcase
    end

    assign prod_full  = {{M{1'b0}}, mul_a[M-1:0]} * {{M{1'b0}}, mul_b[M-1:0]};
    assign prod_shift = prod_full >> Q;
    assign prod_mag   = (|prod_shift[2*M-1:M]) ? MAG_MAX : prod_shift[M-1:0];
    assign prod_sign  = (mul_a[M] ^ mul_b[M]) & (|prod_mag);

    // Sign-magnitude add with saturation on every step.
    always_comb begin
        sum_mag  = '0;
        sum_sign = 1'b0;
        mag_sum  = {1'b0, acc_reg[M-1:0]} + {1'b0, prod_mag};
        if (acc_reg[M] == prod_sign) begin
            sum_mag  = mag_sum[M] ? MAG_MAX : mag_sum[M-1:0];
            sum_sign = acc_reg[M];
        end else if (acc_reg[M-1:0] > prod_mag) begin
            sum_mag  = acc_reg[M-1:0] - prod_mag;
            sum_sign = acc_reg[M];
        end else if (prod_mag > acc_reg[M-1:0]) begin
            sum_mag  = prod_mag - acc_reg[M-1:0];
            sum_sign = prod_sign;
        end
        if (sum_mag == '0) begin
            sum_sign = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_reg   <= '0;
            x1_reg  <= '0;
            y1_reg  <= '0;
            y2_reg  <= '0;
            acc_reg <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (accept) begin
                        x_reg   <= sm_norm(in_data);
                        acc_reg <= '0;
                        if (line_start) begin
                            x1_reg <= '0;
                            y1_reg <= '0;
                            y2_reg <= '0;
                        end
                    end
                end
                T0, T1, T2, T3: acc_reg <= {sum_sign, sum_mag};
                DONE: begin
                    if (out_ready) begin
                        x1_reg <= x_reg;
                        y2_reg <= y1_reg;
                        y1_reg <= acc_reg;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_recursive_gaussian_iir_stage.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// and randomized samples compared against an integer-arithmetic reference model.
module tb_recursive_gaussian_iir_stage;
    localparam int Q = 12;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        line_start = 1'b0;
    logic [15:0] coef_n0 = '0, coef_n1 = '0, coef_d1 = '0, coef_d2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;

    always #5 clk = ~clk;

    recursive_gaussian_iir_stage #(.Q(Q), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .line_start(line_start),
        .coef_n0(coef_n0), .coef_n1(coef_n1), .coef_d1(coef_d1), .coef_d2(coef_d2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    int checks = 0;
    int errors = 0;
    int mx1 = 0, my1 = 0, my2 = 0;

    typedef struct {
        logic [15:0] x;
        logic        ls;
        logic [15:0] n0, n1, d1, d2;
        logic [15:0] exp_y;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp_v);
        end
    endtask

    // Reference model in signed integers: clamp to +/-32767 after every add.
    function automatic int sm2i(input logic [15:0] v);
        int m;
        m = int'(v[14:0]);
        return v[15] ? -m : m;
    endfunction

    function automatic int clamp(input int v);
        if (v > 32767) return 32767;
        if (v < -32767) return -32767;
        return v;
    endfunction

    function automatic int fmul(input int a, input int b);
        int p;
        p = ((a < 0 ? -a : a) * (b < 0 ? -b : b)) >> Q;
        if (p > 32767) p = 32767;
        return ((a < 0) != (b < 0)) ? -p : p;
    endfunction

    function automatic logic [15:0] i2sm(input int v);
        logic [15:0] r;
        if (v < 0) r = {1'b1, 15'(-v)};
        else       r = {1'b0, 15'(v)};
        return r;
    endfunction

    function automatic logic [15:0] model_step(input logic [15:0] x, input logic ls,
                                               input logic [15:0] c0, c1, c2, c3);
        int xi, acc;
        xi = sm2i(x);
        if (ls) begin mx1 = 0; my1 = 0; my2 = 0; end
        acc = 0;
        acc = clamp(acc + fmul(sm2i(c0), xi));
        acc = clamp(acc + fmul(sm2i(c1), mx1));
        acc = clamp(acc + fmul(sm2i(c2), my1));
        acc = clamp(acc + fmul(sm2i(c3), my2));
        mx1 = xi; my2 = my1; my1 = acc;
        return i2sm(acc);
    endfunction

    // Runs one sample: accept, check busy/latency, hold out_ready low bp cycles, handshake.
    task automatic do_sample(input logic [15:0] x, input logic ls,
                             input logic [15:0] c0, c1, c2, c3, input int bp,
                             output logic [15:0] y, output logic [15:0] exp_y, output int waits);
        int lat;
        logic [15:0] held;
        exp_y = model_step(x, ls, c0, c1, c2, c3);
        in_data = x; line_start = ls; in_valid = 1'b1; out_ready = 1'b0;
        coef_n0 = c0; coef_n1 = c1; coef_d1 = c2; coef_d2 = c3;
        waits = 0;
        while (!in_ready && waits < 50) begin @(posedge clk); #1; waits++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready never rose");
        end
        @(posedge clk); #1;
        in_valid = 1'b0; line_start = 1'($urandom); in_data = 16'($urandom);
        coef_n0 = 16'($urandom); coef_n1 = 16'($urandom);
        coef_d1 = 16'($urandom); coef_d2 = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("busy_in_ready", {15'd0, in_ready}, 16'd0);
            @(posedge clk); #1; lat++;
        end
        // Accept edge counts as the 1st edge, so out_valid is seen 4 edges later.
        check("latency", 16'(lat), 16'd4);
        y = out_data;
        held = out_data;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check("bp_valid", {15'd0, out_valid}, 16'd1);
            check("bp_data", out_data, held);
            check("bp_in_ready", {15'd0, in_ready}, 16'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_hs_valid", {15'd0, out_valid}, 16'd0);
        check("post_hs_in_ready", {15'd0, in_ready}, 16'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [7];
        logic [15:0] y, ey;
        int          w;

        tbl[0] = '{16'h0800, 1'b1, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h0800, "passthrough"};
        tbl[1] = '{16'h1000, 1'b1, 16'h0800, 16'h0000, 16'h0800, 16'h0000, 16'h0800, "recursion_a"};
        tbl[2] = '{16'h1000, 1'b0, 16'h0800, 16'h0000, 16'h0800, 16'h0000, 16'h0C00, "recursion_b"};
        tbl[3] = '{16'h1000, 1'b1, 16'h1000, 16'h9000, 16'h0000, 16'h0000, 16'h1000, "cancel_a"};
        tbl[4] = '{16'h1000, 1'b0, 16'h1000, 16'h9000, 16'h0000, 16'h0000, 16'h0000, "cancel_b"};
        tbl[5] = '{16'h7FFF, 1'b1, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, "sat_pos"};
        tbl[6] = '{16'hFFFF, 1'b1, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, "sat_neg"};

        // Reset state
        repeat (3) begin @(posedge clk); #1; end
        check("rst_in_ready", {15'd0, in_ready}, 16'd0);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_out_data", out_data, 16'h0000);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", {15'd0, in_ready}, 16'd1);

        for (int i = 0; i < 7; i++) begin
            do_sample(tbl[i].x, tbl[i].ls, tbl[i].n0, tbl[i].n1, tbl[i].d1, tbl[i].d2, 0, y, ey, w);
            check(tbl[i].name, y, tbl[i].exp_y);
            $display("vec %s x=0x%04h ls=%0d -> y=0x%04h (want 0x%04h)",
                     tbl[i].name, tbl[i].x, tbl[i].ls, y, tbl[i].exp_y);
        end

        // Reset during T2 aborts the sample and clears history (y1 is currently -full scale).
        in_data = 16'h4000; line_start = 1'b0; in_valid = 1'b1;
        coef_n0 = 16'h1000; coef_n1 = 16'h1000; coef_d1 = 16'h1000; coef_d2 = 16'h1000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_low_in_ready", {15'd0, in_ready}, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("midrst_out_valid", {15'd0, out_valid}, 16'd0);
        check("midrst_out_data", out_data, 16'h0000);
        check("midrst_in_ready", {15'd0, in_ready}, 16'd1);
        mx1 = 0; my1 = 0; my2 = 0;
        do_sample(16'h1000, 1'b0, 16'h1000, 16'h0000, 16'h1000, 16'h0000, 0, y, ey, w);
        check("midrst_history", y, 16'h1000);
        $display("reset mid-op: y=0x%04h", y);

        // Backpressure, then immediate acceptance after the handshake.
        do_sample(16'h0800, 1'b1, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 10, y, ey, w);
        check("bp_result", y, 16'h0800);
        do_sample(16'h8000, 1'b0, 16'h1000, 16'h1000, 16'h0000, 16'h0000, 0, y, ey, w);
        check("bp_next_accept_waits", 16'(w), 16'd0);
        check("neg_zero_input", y, 16'h0800);
        $display("backpressure: y=0x%04h waits=%0d", y, w);

        // Randomized samples against the reference model.
        for (int n = 0; n < 150; n++) begin
            logic [15:0] c [4];
            logic [15:0] x;
            logic        ls;
            for (int k = 0; k < 4; k++) begin
                c[k] = {1'($urandom), 15'($urandom_range(0, 16'h1C00))};
                if ($urandom_range(0, 19) == 0) c[k] = 16'h8000;
            end
            x  = 16'($urandom);
            if ($urandom_range(0, 15) == 0) x = 16'h8000;
            ls = ($urandom_range(0, 4) == 0);
            repeat ($urandom_range(0, 2)) begin
                line_start = 1'($urandom);
                @(posedge clk); #1;
            end
            do_sample(x, ls, c[0], c[1], c[2], c[3], $urandom_range(0, 3), y, ey, w);
            check("random", y, ey);
            $display("rand %0d x=0x%04h ls=%0d -> y=0x%04h model=0x%04h", n, x, ls, y, ey);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
